gshare_predictor: RTL and testbench

- Parametrised successor to the single-counter bimodal predictor: a table of 2^IDX_BITS saturating counters, indexed either by PC alone (bimodal mode) or by PC XOR global history (gshare mode).
- Instantiated inside branch_controller in place of the current predictor. Keeps the existing request/feedback port set and adds a ready flag and an overflow flag.
- Holds an in-flight index FIFO, so each feedback updates the same entry its prediction read.

---
 rtl/gshare_predictor.sv | 179 +++++++++++++++++
 tb/tb_gshare_predictor.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/gshare_predictor.sv
// gshare_predictor: table of saturating counters indexed by PC, or by PC xor
// global history, with an in-flight index FIFO so each feedback updates the
// entry its prediction read.
// Ports: clk/rst (sync, active-high); i_req_* request, o_req_prediction
// (combinational, 1 = TAKEN); i_fb_* resolved-branch feedback; o_ready is
// high once the table sweep is done; o_overflow is sticky on a dropped push.
`timescale 1ns/1ps
module gshare_predictor #(
   parameter int ADDR_WIDTH = 32,
   parameter int IDX_BITS   = 10,
   parameter int CTR_BITS   = 2,
   parameter int HIST_LEN   = 8,
   parameter int USE_GSHARE = 1,
   parameter int INFLIGHT   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_req_valid,
   input  logic [ADDR_WIDTH-1:0] i_req_pc,
   input  logic [ADDR_WIDTH-1:0] i_req_target,
   output logic                  o_req_prediction,
   output logic                  o_ready,
   input  logic                  i_fb_valid,
   input  logic [ADDR_WIDTH-1:0] i_fb_pc,
   input  logic                  i_fb_prediction,
   input  logic                  i_fb_outcome,
   output logic                  o_overflow
);

   localparam int ENTRIES = 1 << IDX_BITS;
   localparam int PTR_W   = $clog2(INFLIGHT);
   localparam int CNT_W   = PTR_W + 1;

   localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
   localparam logic [CTR_BITS-1:0] CTR_WEAK =
      {1'b1, {(CTR_BITS-1){1'b0}}};
   localparam logic TAKEN = 1'b1;

   typedef enum logic {INIT, RUN} state_t;

   state_t                state_q, state_d;
   logic [IDX_BITS-1:0]   sweep_q, sweep_d;
   logic [HIST_LEN-1:0]   ghr_q, ghr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  ready_q;
   logic                  ovf_q, ovf_d;

   logic [CTR_BITS-1:0]   table_q [ENTRIES];
   logic [IDX_BITS-1:0]   fifo_q  [INFLIGHT];

   logic                  tbl_we;
   logic [IDX_BITS-1:0]   tbl_waddr;
   logic [CTR_BITS-1:0]   tbl_wdata;
   logic                  fifo_we;
   logic                  pop;
   logic                  mispred;
   logic                  push_try;
   logic                  full;
   logic [IDX_BITS-1:0]   upd_idx;
   logic [CTR_BITS-1:0]   ctr;
   logic [IDX_BITS-1:0]   req_idx;
   logic [IDX_BITS-1:0]   fb_idx;

   function automatic logic [IDX_BITS-1:0] idx_of(
      input logic [ADDR_WIDTH-1:0] pc,
      input logic [HIST_LEN-1:0]   hist
   );
      logic [IDX_BITS-1:0] p;
      logic [IDX_BITS-1:0] h;
      p = pc[IDX_BITS+1:2];
      h = IDX_BITS'(hist);
      return (USE_GSHARE != 0) ? (p ^ h) : p;
   endfunction

   assign req_idx = idx_of(i_req_pc, ghr_q);
   assign fb_idx  = idx_of(i_fb_pc, ghr_q);

   // Reads the pre-update table, so a same-cycle feedback is not visible.
   assign o_req_prediction =
      (state_q == RUN) && table_q[req_idx][CTR_BITS-1];
   assign o_ready    = ready_q;
   assign o_overflow = ovf_q;

   always_comb begin
      state_d   = state_q;
      sweep_d   = sweep_q;
      ghr_d     = ghr_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      tbl_we    = 1'b0;
      tbl_waddr = sweep_q;
      tbl_wdata = CTR_WEAK;
      fifo_we   = 1'b0;
      pop       = 1'b0;
      mispred   = 1'b0;
      push_try  = 1'b0;
      full      = 1'b0;
      upd_idx   = fb_idx;
      ctr       = '0;

      if (state_q == INIT) begin
         tbl_we  = 1'b1;
         sweep_d = sweep_q + IDX_BITS'(1);
         if (sweep_q == IDX_BITS'(ENTRIES - 1))
            state_d = RUN;
      end else begin
         pop      = i_fb_valid && (cnt_q != '0);
         mispred  = i_fb_valid && (i_fb_prediction != i_fb_outcome);
         push_try = i_req_valid && !mispred;
         full     = (cnt_q == CNT_W'(INFLIGHT));
         // A same-cycle pop frees the slot the push needs.
         fifo_we  = push_try && (!full || pop);
         if (push_try && full && !pop)
            ovf_d = 1'b1;

         if (i_fb_valid) begin
            upd_idx   = pop ? fifo_q[rd_ptr_q] : fb_idx;
            ctr       = table_q[upd_idx];
            tbl_we    = 1'b1;
            tbl_waddr = upd_idx;
            if (i_fb_outcome == TAKEN)
               tbl_wdata = (ctr == CTR_MAX) ? ctr : ctr + CTR_BITS'(1);
            else
               tbl_wdata = (ctr == '0) ? ctr : ctr - CTR_BITS'(1);
            ghr_d = (ghr_q << 1) | HIST_LEN'(i_fb_outcome);
         end

         // Younger entries are wrong-path after a mispredict.
         if (mispred) begin
            rd_ptr_d = wr_ptr_q;
            cnt_d    = '0;
         end else begin
            if (pop)
               rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (fifo_we)
               wr_ptr_d = wr_ptr_q + PTR_W'(1);
            cnt_d = cnt_q + CNT_W'(fifo_we) - CNT_W'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= INIT;
         sweep_q  <= '0;
         ghr_q    <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         ready_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sweep_q  <= sweep_d;
         ghr_q    <= ghr_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         ready_q  <= (state_d == RUN);
         ovf_q    <= ovf_d;
      end
   end

   // Storage needs no reset: the INIT sweep rewrites every entry.
   always_ff @(posedge clk) begin
      if (!rst && tbl_we)
         table_q[tbl_waddr] <= tbl_wdata;
      if (!rst && fifo_we)
         fifo_q[wr_ptr_q] <= req_idx;
   end

   logic unused_ok;
   assign unused_ok = ^{i_req_target, i_req_pc, i_fb_pc};

endmodule

// File: tb/tb_gshare_predictor.sv
// tb_gshare_predictor: directed bench for gshare_predictor, one gshare
// instance and one bimodal instance driven by the same stimulus.
`timescale 1ns/1ps
module tb_gshare_predictor;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic [31:0] req_pc = '0;
   logic [31:0] req_tgt = '0;
   logic        fb_valid = 1'b0;
   logic [31:0] fb_pc = '0;
   logic        fb_pred = 1'b0;
   logic        fb_out = 1'b0;

   logic gs_pred, gs_ready, gs_ovf;
   logic bim_pred, bim_ready, bim_ovf;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   gshare_predictor #(
      .ADDR_WIDTH(32), .IDX_BITS(4), .CTR_BITS(2),
      .HIST_LEN(4), .USE_GSHARE(1), .INFLIGHT(4)
   ) u_gs (
      .clk(clk), .rst(rst),
      .i_req_valid(req_valid), .i_req_pc(req_pc),
      .i_req_target(req_tgt),
      .o_req_prediction(gs_pred), .o_ready(gs_ready),
      .i_fb_valid(fb_valid), .i_fb_pc(fb_pc),
      .i_fb_prediction(fb_pred), .i_fb_outcome(fb_out),
      .o_overflow(gs_ovf)
   );

   gshare_predictor #(
      .ADDR_WIDTH(32), .IDX_BITS(4), .CTR_BITS(2),
      .HIST_LEN(4), .USE_GSHARE(0), .INFLIGHT(4)
   ) u_bim (
      .clk(clk), .rst(rst),
      .i_req_valid(req_valid), .i_req_pc(req_pc),
      .i_req_target(req_tgt),
      .o_req_prediction(bim_pred), .o_ready(bim_ready),
      .i_fb_valid(fb_valid), .i_fb_pc(fb_pc),
      .i_fb_prediction(fb_pred), .i_fb_outcome(fb_out),
      .o_overflow(bim_ovf)
   );

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req_valid = 1'b0;
      fb_valid  = 1'b0;
   endtask

   task automatic reset_dut();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (16) tick();
      @(negedge clk);
      check("ready_after_rst", gs_ready, 1);
   endtask

   task automatic fb(input logic [31:0] pc,
                     input logic p, input logic o);
      fb_valid = 1'b1;
      fb_pc    = pc;
      fb_pred  = p;
      fb_out   = o;
      tick();
      fb_valid = 1'b0;
   endtask

   task automatic req(input logic [31:0] pc);
      req_valid = 1'b1;
      req_pc    = pc;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic probe(input logic [31:0] pc);
      req_pc = pc;
      #1;
   endtask

   logic [1:0] sat_ctr [9] = '{2'd1, 2'd0, 2'd0, 2'd0,
                               2'd1, 2'd2, 2'd3, 2'd3, 2'd2};
   logic       sat_out [9] = '{1'b0, 1'b0, 1'b0, 1'b0,
                               1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset sequencing: ready after 16 sweep cycles, requests ignored.
      rst = 1'b1;
      req_valid = 1'b1;
      req_pc = 32'h40;
      tick();
      rst = 1'b0;
      for (int c = 1; c <= 17; c++) begin
         if (c == 17) req_valid = 1'b0;
         @(negedge clk);
         check($sformatf("ready_c%0d", c), gs_ready, (c == 17));
         if (c == 2) check("pred_init", gs_pred, 0);
         if (c == 17) begin
            check("pred_run", gs_pred, 1);
            check("bim_ready", bim_ready, 1);
            check("ovf_after_init", gs_ovf, 0);
         end
         if (c < 17) tick();
      end

      // Saturation on the bimodal instance, pc 0x40 -> entry 0.
      reset_dut();
      req_pc = 32'h40;
      for (int i = 0; i < 9; i++) begin
         fb(32'h40, sat_out[i], sat_out[i]);
         @(negedge clk);
         check($sformatf("sat_pred%0d", i), bim_pred,
               {31'd0, sat_ctr[i][1]});
         check($sformatf("sat_ctr%0d", i),
               u_bim.table_q[0], sat_ctr[i]);
      end

      // Gshare aliasing: history shifts pc 0x40 between entries.
      reset_dut();
      fb(32'h7C, 1'b1, 1'b1);
      @(negedge clk);
      probe(32'h40);
      check("alias_pred_g1", gs_pred, 1);
      check("alias_e15", u_gs.table_q[15], 3);
      fb(32'h44, 1'b0, 1'b0);
      @(negedge clk);
      probe(32'h48);
      check("alias_pred_e0", gs_pred, 0);
      probe(32'h4C);
      check("alias_pred_e1", gs_pred, 1);
      check("alias_e0", u_gs.table_q[0], 1);
      check("alias_e1", u_gs.table_q[1], 2);

      // FIFO ordering: updates use the indices latched at request time.
      reset_dut();
      req(32'h40);
      req(32'h44);
      fb(32'h60, 1'b1, 1'b1);
      fb(32'h44, 1'b1, 1'b1);
      @(negedge clk);
      check("fifo_e0", u_gs.table_q[0], 3);
      check("fifo_e1", u_gs.table_q[1], 3);
      check("fifo_e8", u_gs.table_q[8], 2);
      check("fifo_cnt", u_gs.cnt_q, 0);

      // Mispredict flush with a same-cycle request on the updated entry.
      reset_dut();
      req(32'h40);
      req(32'h44);
      req(32'h48);
      fb_valid  = 1'b1;
      fb_pc     = 32'h40;
      fb_pred   = 1'b1;
      fb_out    = 1'b0;
      req_valid = 1'b1;
      req_pc    = 32'h40;
      @(negedge clk);
      check("flush_pre_update", gs_pred, 1);
      tick();
      idle();
      @(negedge clk);
      check("flush_cnt", u_gs.cnt_q, 0);
      fb(32'h5C, 1'b0, 1'b0);
      @(negedge clk);
      check("flush_e0", u_gs.table_q[0], 1);
      check("flush_e7", u_gs.table_q[7], 1);
      check("flush_e1", u_gs.table_q[1], 2);

      // Overflow: full push+pop is fine, a lone push on full is dropped.
      reset_dut();
      req(32'h40);
      req(32'h44);
      req(32'h48);
      req(32'h4C);
      @(negedge clk);
      check("ovf_full", gs_ovf, 0);
      fb_valid  = 1'b1;
      fb_pc     = 32'h40;
      fb_pred   = 1'b1;
      fb_out    = 1'b1;
      req_valid = 1'b1;
      req_pc    = 32'h50;
      tick();
      idle();
      @(negedge clk);
      check("ovf_pushpop", gs_ovf, 0);
      check("ovf_pushpop_cnt", u_gs.cnt_q, 4);
      req(32'h54);
      @(negedge clk);
      check("ovf_set", gs_ovf, 1);
      check("ovf_set_bim", bim_ovf, 1);
      repeat (3) tick();
      @(negedge clk);
      check("ovf_sticky", gs_ovf, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("ovf_cleared", gs_ovf, 0);
      check("ready_cleared", gs_ready, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
